bist_pattern_gen: RTL and testbench
===================================

// Module: bist_pattern_gen
// PURPOSE
//  Stimulus side of the systolic-array BIST: drives LFSR-derived test words onto
//  left_in_bus/top_in_bus of fsm_systolic, one PE test slot at a time. Each slot
//  is held stable, then released on the fault-detection FSM's per-PE done/fail
//  handshake. Builds a ROWSxCOLS fault map for the downstream BISR remap logic.
// PARAMETERS
//  ROWS        4        array rows (PE row index range 0..ROWS-1)
//  COLS        4        array columns
//  WORD_SIZE   16       lane width; lane word = low WORD_SIZE bits of 16-bit LFSR word (WORD_SIZE<=16)
//  HOLD_CYCLES 4        cycles the pattern is held before an ack is accepted (>=1)
//  LFSR_SEED   16'hACE1 LFSR value after reset / restart (must be nonzero)
// PORTS
//  clk               in   1               system clock
//  rst               in   1               synchronous, active-high reset
//  start_in          in   1               begin sweep; sampled in IDLE or DONE only
//  pe_done_in        in   1               detector finished checking current PE
//  pe_fail_in        in   1               current PE miscompared; valid with pe_done_in
//  left_in_bus       out  ROWS*WORD_SIZE  row-lane stimulus, lane r at [r*WORD_SIZE +: WORD_SIZE]
//  top_in_bus        out  COLS*WORD_SIZE  column-lane stimulus, lane c likewise
//  ctl_stat_bit_in   out  1               array stationary-load control, high in LOAD/HOLD
//  pe_row_out        out  $clog2(ROWS)    row of PE under test
//  pe_col_out        out  $clog2(COLS)    column of PE under test
//  pattern_valid_out out  1               buses stable (HOLD and WAIT_ACK)
//  busy_out          out  1               sweep in progress (any state but IDLE/DONE)
//  done_out          out  1               sweep complete, fault map final
//  fault_map_out     out  ROWS*COLS       bit row*COLS+col = 1: PE faulty
// BEHAVIOUR
//  Reset: state=IDLE, LFSR=LFSR_SEED, all outputs 0, row/col/hold counter 0. Applies mid-sweep too.
//  LFSR: 16-bit Galois, right shift, taps 16'hB400; lfsr_n = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
//  Lanes (latched in LOAD): left lane r = rotl(lfsr_n, r mod 16); top lane c = ~rotl(lfsr_n, c mod 16).
//  Buses change only in LOAD and are held in all other states. All outputs are registered.
//  FSM:
//   IDLE     start_in -> LOAD (clear fault_map, row=col=0)
//   LOAD     1 cycle: step LFSR, drive buses -> HOLD
//   HOLD     HOLD_CYCLES cycles (counter 0..HOLD_CYCLES-1) -> WAIT_ACK; pe_done_in ignored here
//   WAIT_ACK wait pe_done_in; on it, fault_map[row*COLS+col] <= pe_fail_in -> NEXT
//   NEXT     col+1; col==COLS-1 wraps to 0 with row+1; last PE (ROWS-1,COLS-1) -> DONE else LOAD
//   DONE     done_out=1, map held; start_in -> LOAD (map cleared, LFSR NOT reseeded)
//  start_in outside IDLE/DONE ignored. pe_fail_in without pe_done_in ignored.
//  Slot length with pe_done_in tied high = HOLD_CYCLES+3 cycles; full sweep = ROWS*COLS*(HOLD_CYCLES+3).
// CONFIGURATION
//  BIST_STOP_ON_FAIL_EN defined: pe_done_in with pe_fail_in in WAIT_ACK goes straight to DONE;
//   pe_row_out/pe_col_out freeze on the failing PE; only that bit set in fault_map_out.
//  Not defined: sweep always visits all ROWS*COLS PEs regardless of failures.
// TESTING
//  1 rst, start_in pulse, pe_done_in=1, pe_fail_in=0 -> first LOAD: left lane0=16'hE270,
//    lane1=16'hC4E1, top lane0=16'h1D8F; done_out high 112 cycles after start edge, fault_map=0.
//  2 pe_fail_in=1 only when row=2,col=1 -> fault_map_out=16'h0200 at done_out.
//  3 pe_done_in held high from start -> no ack during HOLD; pattern_valid_out high >=HOLD_CYCLES cycles per PE.
//  4 rst asserted during PE (1,3) WAIT_ACK -> next cycle all outputs 0, IDLE; restart repeats test 1 values.
//  5 start_in in DONE -> map cleared, new sweep with LFSR continuing (lane0 != 16'hE270);
//    start_in pulsed mid-sweep -> no effect.
//  6 BIST_STOP_ON_FAIL_EN, fail at (0,2) -> done_out at that PE, pe_row_out=0, pe_col_out=2, map=16'h0004.

Source files
------------

// File: rtl/bist_pattern_gen.sv
// BIST stimulus generator: LFSR-derived lane patterns, one PE slot at a time.
// Optional BIST_STOP_ON_FAIL_EN: end the sweep on the first failing PE.
module bist_pattern_gen #(
    parameter int          ROWS        = 4,
    parameter int          COLS        = 4,
    parameter int          WORD_SIZE   = 16,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_in,
    input  logic                      pe_done_in,
    input  logic                      pe_fail_in,
    output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
    output logic [COLS*WORD_SIZE-1:0] top_in_bus,
    output logic                      ctl_stat_bit_in,
    output logic [$clog2(ROWS)-1:0]   pe_row_out,
    output logic [$clog2(COLS)-1:0]   pe_col_out,
    output logic                      pattern_valid_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic [ROWS*COLS-1:0]      fault_map_out
);

    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int NPE = ROWS * COLS;
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [ROWS*WORD_SIZE-1:0] left_q, left_d;
    logic [COLS*WORD_SIZE-1:0] top_q, top_d;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [NPE-1:0]          map_q, map_d;
    logic                    ctl_q, ctl_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [15:0]             lfsr_n;
    logic [ROWS*WORD_SIZE-1:0] left_lane;
    logic [COLS*WORD_SIZE-1:0] top_lane;
    int                      pe_idx;
    logic                    last_pe;

    function automatic logic [15:0] rotl16(input logic [15:0] x,
                                           input logic [3:0]  n);
        logic [31:0] t;
        t = {x, x} << n;
        return t[31:16];
    endfunction

    assign lfsr_n = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    for (genvar r = 0; r < ROWS; r++) begin : g_left
        logic [15:0] rot;
        assign rot = rotl16(lfsr_n, 4'(r % 16));
        assign left_lane[r*WORD_SIZE +: WORD_SIZE] = rot[WORD_SIZE-1:0];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_top
        logic [15:0] rot;
        assign rot = rotl16(lfsr_n, 4'(c % 16));
        assign top_lane[c*WORD_SIZE +: WORD_SIZE] = ~rot[WORD_SIZE-1:0];
    end

    assign pe_idx  = int'(row_q) * COLS + int'(col_q);
    assign last_pe = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        left_d  = left_q;
        top_d   = top_q;
        row_d   = row_q;
        col_d   = col_q;
        hold_d  = hold_q;
        map_d   = map_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    state_d = S_LOAD;
                    map_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    hold_d  = '0;
                end
            end
            S_LOAD: begin
                lfsr_d  = lfsr_n;
                left_d  = left_lane;
                top_d   = top_lane;
                hold_d  = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_WAIT: begin
                if (pe_done_in) begin
                    for (int i = 0; i < NPE; i++) begin
                        if (i == pe_idx) map_d[i] = pe_fail_in;
                    end
`ifdef BIST_STOP_ON_FAIL_EN
                    state_d = pe_fail_in ? S_DONE : S_NEXT;
`else
                    state_d = S_NEXT;
`endif
                end
            end
            S_NEXT: begin
                if (last_pe) begin
                    state_d = S_DONE;
                end else if (col_q == CW'(COLS - 1)) begin
                    col_d   = '0;
                    row_d   = row_q + RW'(1);
                    state_d = S_LOAD;
                end else begin
                    col_d   = col_q + CW'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ctl_d   = (state_d == S_LOAD) || (state_d == S_HOLD);
        valid_d = (state_d == S_HOLD) || (state_d == S_WAIT);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            left_q  <= '0;
            top_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            hold_q  <= '0;
            map_q   <= '0;
            ctl_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            left_q  <= left_d;
            top_q   <= top_d;
            row_q   <= row_d;
            col_q   <= col_d;
            hold_q  <= hold_d;
            map_q   <= map_d;
            ctl_q   <= ctl_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign left_in_bus       = left_q;
    assign top_in_bus        = top_q;
    assign ctl_stat_bit_in   = ctl_q;
    assign pe_row_out        = row_q;
    assign pe_col_out        = col_q;
    assign pattern_valid_out = valid_q;
    assign busy_out          = busy_q;
    assign done_out          = done_q;
    assign fault_map_out     = map_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Scoreboard bench for bist_pattern_gen: expected slots/done pushed by the
// stimulus, popped and compared by a monitor on DUT output events.
module tb_bist_pattern_gen;

    localparam int          ROWS = 4;
    localparam int          COLS = 4;
    localparam int          W    = 16;
    localparam int          HOLD = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [63:0] LEFT0 = 64'h1387_89C3_C4E1_E270;
    localparam logic [63:0] TOP0  = 64'hEC78_763C_3B1E_1D8F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic        pe_done_in = 1'b1;
    logic        pe_fail_in = 1'b0;
    logic [63:0] left_in_bus;
    logic [63:0] top_in_bus;
    logic        ctl_stat_bit_in;
    logic [1:0]  pe_row_out;
    logic [1:0]  pe_col_out;
    logic        pattern_valid_out;
    logic        busy_out;
    logic        done_out;
    logic [15:0] fault_map_out;

    bist_pattern_gen #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W),
        .HOLD_CYCLES(HOLD), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start_in(start_in),
        .pe_done_in(pe_done_in), .pe_fail_in(pe_fail_in),
        .left_in_bus(left_in_bus), .top_in_bus(top_in_bus),
        .ctl_stat_bit_in(ctl_stat_bit_in),
        .pe_row_out(pe_row_out), .pe_col_out(pe_col_out),
        .pattern_valid_out(pattern_valid_out),
        .busy_out(busy_out), .done_out(done_out),
        .fault_map_out(fault_map_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [63:0] left;
        logic [63:0] top;
        logic [1:0]  row;
        logic [1:0]  col;
        logic [15:0] map;
        int          cycles;
        bit          chk_rc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [15:0] m_lfsr = SEED;
    int          fail_row = 0;
    int          fail_col = 0;
    bit          fail_en = 0;
    bit          stall_en = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    function automatic logic [15:0] m_rotl(input logic [15:0] x, input int n);
        logic [15:0] y;
        for (int i = 0; i < 16; i++) y[(i + n) % 16] = x[i];
        return y;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake drivers react to the PE currently under test.
    always @(negedge clk) begin
        pe_fail_in = fail_en && (int'(pe_row_out) == fail_row)
                     && (int'(pe_col_out) == fail_col);
        pe_done_in = !(stall_en && pe_row_out == 2'd1 && pe_col_out == 2'd3);
    end

    // Monitor: pop and compare on each slot start and on sweep completion.
    bit pv_prev = 0;
    bit dn_prev = 0;
    int pv_len = 0;
    always @(negedge clk) begin
        exp_t e;
        if (pattern_valid_out && !pv_prev) begin
            if (q.size() == 0 || q[0].is_done) begin
                chk("slot_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("slot_left", left_in_bus, e.left);
                chk("slot_top", top_in_bus, e.top);
                chk("slot_row", 64'(pe_row_out), 64'(e.row));
                chk("slot_col", 64'(pe_col_out), 64'(e.col));
                chk("slot_ctl", 64'(ctl_stat_bit_in), 1);
            end
        end
        if (pattern_valid_out) begin
            pv_len++;
        end else if (pv_prev) begin
            chk("hold_len_ok", 64'(pv_len >= HOLD + 1), 1);
            pv_len = 0;
        end
        if (done_out && !dn_prev) begin
            if (q.size() == 0 || !q[0].is_done) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_map", 64'(fault_map_out), 64'(e.map));
                chk("done_cycles", 64'(cyc - start_cyc), 64'(e.cycles));
                chk("done_busy", 64'(busy_out), 0);
                if (e.chk_rc) begin
                    chk("done_row", 64'(pe_row_out), 64'(e.row));
                    chk("done_col", 64'(pe_col_out), 64'(e.col));
                end
            end
        end
        pv_prev = pattern_valid_out;
        dn_prev = done_out;
    end

    task automatic push_slots(input int n);
        exp_t e;
        logic [15:0] r;
        for (int k = 0; k < n; k++) begin
            e = '{default: '0};
            if (k == 0 && m_lfsr == SEED) begin
                e.left = LEFT0;
                e.top  = TOP0;
                m_lfsr = m_step(m_lfsr);
            end else begin
                m_lfsr = m_step(m_lfsr);
                for (int l = 0; l < 4; l++) begin
                    r = m_rotl(m_lfsr, l);
                    e.left[l*16 +: 16] = r;
                    e.top[l*16 +: 16]  = ~r;
                end
            end
            e.row = 2'(k / COLS);
            e.col = 2'(k % COLS);
            q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        start_cyc = cyc;
        chk("start_map_clear", 64'(fault_map_out), 0);
        chk("start_busy", 64'(busy_out), 1);
        chk("start_done_low", 64'(done_out), 0);
    endtask

    task automatic run_sweep(input int fr, input int fc, input bit fe,
                             input bit mid);
        exp_t e;
        int   n;
        bit   got;
        bit   stop;
`ifdef BIST_STOP_ON_FAIL_EN
        stop = fe;
`else
        stop = 0;
`endif
        n = stop ? fr * COLS + fc + 1 : ROWS * COLS;
        push_slots(n);
        e = '{default: '0};
        e.is_done = 1;
        e.map     = fe ? 16'(1 << (fr * COLS + fc)) : 16'h0000;
        e.cycles  = stop ? 7 * (n - 1) + 6 : 7 * n;
        e.chk_rc  = stop;
        e.row     = 2'(fr);
        e.col     = 2'(fc);
        q.push_back(e);
        fail_row = fr;
        fail_col = fc;
        fail_en  = fe;
        pulse_start();
        if (mid) begin
            repeat (20) @(negedge clk);
            start_in = 1'b1;
            @(negedge clk);
            start_in = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = done_out;
        end
        chk("done_reached", 64'(got), 1);
        @(negedge clk);
        chk("sb_empty", 64'(q.size()), 0);
        fail_en = 0;
        q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_left"}, left_in_bus, 0);
        chk({tag, "_top"}, top_in_bus, 0);
        chk({tag, "_map"}, 64'(fault_map_out), 0);
        chk({tag, "_flags"}, 64'({ctl_stat_bit_in, pattern_valid_out,
                                  busy_out, done_out}), 0);
        chk({tag, "_rowcol"}, 64'({pe_row_out, pe_col_out}), 0);
    endtask

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        run_sweep(0, 0, 0, 0);
`ifdef BIST_STOP_ON_FAIL_EN
        run_sweep(0, 2, 1, 0);
`else
        run_sweep(2, 1, 1, 0);
`endif
        run_sweep(0, 0, 0, 1);

        stall_en = 1;
        push_slots(8);
        pulse_start();
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = pattern_valid_out && !ctl_stat_bit_in
                  && pe_row_out == 2'd1 && pe_col_out == 2'd3;
        end
        chk("stall_reached", 64'(got), 1);
        repeat (3) @(negedge clk);
        chk("stall_sb_empty", 64'(q.size()), 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0;
        stall_en = 0;
        q.delete();
        m_lfsr = SEED;
        run_sweep(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
